// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Sits between the CPU control unit and the multicycle multiply (Booth) and
//   divide units. It accepts one MULT or DIV request at a time, latches the
//   operands, launches the selected unit with a one-cycle start pulse and
//   waits for that unit's done. It owns the architectural HI/LO registers.
//   While an operation is in flight it holds busy high to stall the control
//   unit. It also reports divide-by-zero and unit timeout as one-cycle pulses.
//
// Ports
//   clk, reset            system clock (rising edge), async active-high reset
//   op_mult, op_div       operation requests, sampled only in IDLE
//   value_A, value_B      operands (multiplicand/dividend, multiplier/divisor)
//   wr_hi, wr_lo, wr_data MTHI/MTLO write strobes and data
//   mult_start/div_start  one-cycle launch pulses to the units
//   mult_done/div_done    unit result valid
//   mult_hi/lo, div_hi/lo unit results (div: hi = remainder, lo = quotient)
//   unit_A, unit_B        latched operands, shared by both units
//   busy                  stall to the control unit
//   done                  one-cycle pulse: HI/LO updated by a mult/div
//   div_zero              one-cycle pulse: divide by zero, nothing launched
//   timeout               one-cycle pulse: unit did not finish in time
//   hi, lo                architectural HI/LO registers
//
// State table
//   state    | meaning
//   IDLE     | no operation in flight; accepts requests and MTHI/MTLO writes
//   MULT_RUN | multiplier launched; waiting for mult_done or timeout
//   DIV_RUN  | divider launched; waiting for div_done or timeout

module muldiv_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_mult,
    input  logic             op_div,
    input  logic [WIDTH-1:0] value_A,
    input  logic [WIDTH-1:0] value_B,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             mult_start,
    input  logic             mult_done,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    output logic             div_start,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    output logic [WIDTH-1:0] unit_A,
    output logic [WIDTH-1:0] unit_B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             timeout,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2
    } state_t;

    // Counter value at which the run is abandoned: the edge sampling this
    // value is the TIMEOUT-th edge after launch.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            unit_A     <= '0;
            unit_B     <= '0;
            hi         <= '0;
            lo         <= '0;
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            // All pulse outputs default low so none can last two cycles.
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            timeout    <= 1'b0;

            case (state)
                IDLE: begin
                    if (op_mult) begin
                        unit_A     <= value_A;
                        unit_B     <= value_B;
                        cnt        <= '0;
                        mult_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= MULT_RUN;
                    end else if (op_div && (value_B != '0)) begin
                        unit_A    <= value_A;
                        unit_B    <= value_B;
                        cnt       <= '0;
                        div_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= DIV_RUN;
                    end else begin
                        // Nothing launched this edge, so MTHI/MTLO may land.
                        // A divide by zero is not a launch and does not
                        // block a write arriving in the same cycle.
                        if (op_div) begin
                            div_zero <= 1'b1;
                        end
                        if (wr_hi) begin
                            hi <= wr_data;
                        end
                        if (wr_lo) begin
                            lo <= wr_data;
                        end
                    end
                end

                MULT_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (mult_done) begin
                        hi    <= mult_hi;
                        lo    <= mult_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end

                DIV_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (div_done) begin
                        hi    <= div_hi;
                        lo    <= div_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: behavioural multiply/divide unit models
// with programmable latency, directed scenarios, then randomized operations.

module tb_muldiv_sequencer;

    localparam int W  = 32;
    localparam int TO = 40;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_mult, op_div;
    logic [W-1:0] value_A, value_B;
    logic         wr_hi, wr_lo;
    logic [W-1:0] wr_data;
    logic         mult_start, mult_done;
    logic [W-1:0] mult_hi, mult_lo;
    logic         div_start, div_done;
    logic [W-1:0] div_hi, div_lo;
    logic [W-1:0] unit_A, unit_B;
    logic         busy, done, div_zero, timeout;
    logic [W-1:0] hi, lo;

    muldiv_sequencer #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .op_mult(op_mult), .op_div(op_div),
        .value_A(value_A), .value_B(value_B),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .mult_start(mult_start), .mult_done(mult_done),
        .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_start(div_start), .div_done(div_done),
        .div_hi(div_hi), .div_lo(div_lo),
        .unit_A(unit_A), .unit_B(unit_B),
        .busy(busy), .done(done), .div_zero(div_zero), .timeout(timeout),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mul64(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // {remainder, quotient}, truncating toward zero
    function automatic logic [63:0] div64(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb, q, r;
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    // ---------------- unit models ----------------
    // *_lat = cycles after the start pulse at which done is raised (0 = never).
    // With noise_en set, the idle unit throws a stray done with junk data one
    // cycle after the other unit is launched.
    int m_lat = 0, d_lat = 0;
    int m_cnt = 0, d_cnt = 0, mn_cnt = 0, dn_cnt = 0;
    bit noise_en = 1'b0;

    always @(negedge clk) begin
        logic [63:0] r;
        mult_done = 1'b0;
        div_done  = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) mult_done = 1'b1;
        end
        if (d_cnt > 0) begin
            d_cnt--;
            if (d_cnt == 0) div_done = 1'b1;
        end
        if (mn_cnt > 0) begin
            mn_cnt--;
            if (mn_cnt == 0) begin
                mult_done = 1'b1;
                mult_hi   = $urandom;
                mult_lo   = $urandom;
            end
        end
        if (dn_cnt > 0) begin
            dn_cnt--;
            if (dn_cnt == 0) begin
                div_done = 1'b1;
                div_hi   = $urandom;
                div_lo   = $urandom;
            end
        end
        if (mult_start) begin
            r       = mul64(unit_A, unit_B);
            mult_hi = r[63:32];
            mult_lo = r[31:0];
            if (m_lat > 0) m_cnt = m_lat;
            if (noise_en) dn_cnt = 1;
        end
        if (div_start) begin
            if (unit_B != 0) begin
                r      = div64(unit_A, unit_B);
                div_hi = r[63:32];
                div_lo = r[31:0];
            end
            if (d_lat > 0) d_cnt = d_lat;
            if (noise_en) mn_cnt = 1;
        end
    end

    // ---------------- pulse-width monitor ----------------
    logic [4:0] prev_pulse = '0;
    always @(negedge clk) begin
        logic [4:0] cur;
        cur = {done, div_zero, timeout, mult_start, div_start};
        if (reset) begin
            prev_pulse = '0;
        end else begin
            if ((cur & prev_pulse) != 0)
                check("pulse_width", 64'(cur & prev_pulse), 64'(0));
            prev_pulse = cur;
        end
    end

    // ---------------- reference state ----------------
    logic [W-1:0] exp_hi = '0, exp_lo = '0;

    // Issue one request at the current negedge and observe the whole operation.
    // poke: while the unit runs, drive both ops and both writes (data pd).
    task automatic run_op(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input bit whi, input bit wlo, input logic [W-1:0] wd,
                          input bit poke, input logic [W-1:0] pd, input bit noise);
        bit l_mult, l_div, dz, launched, do_poke;
        int ncyc, exp_busy;
        int ms_cnt, ms_first, ds_cnt, busy_cnt, done_cnt, done_cyc, to_cnt, to_cyc, dz_cnt, dz_cyc;
        logic [W-1:0] ua, ub;
        logic [63:0] res;

        l_mult   = m;
        l_div    = !m && d && (b != 0);
        dz       = !m && d && (b == 0);
        launched = l_mult || l_div;
        do_poke  = poke && launched && (lat == 0 || lat >= 3);
        ncyc     = !launched ? 4 : (lat == 0 ? TO + 4 : lat + 4);
        exp_busy = !launched ? 0 : (lat == 0 ? TO : lat + 1);

        if (launched && lat > 0) begin
            res = l_mult ? mul64(a, b) : div64(a, b);
            exp_hi = res[63:32];
            exp_lo = res[31:0];
        end else if (!launched) begin
            if (whi) exp_hi = wd;
            if (wlo) exp_lo = wd;
        end

        m_lat    = l_mult ? lat : 0;
        d_lat    = l_div ? lat : 0;
        noise_en = noise;
        ms_cnt = 0; ms_first = 0; ds_cnt = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
        to_cnt = 0; to_cyc = 0; dz_cnt = 0; dz_cyc = 0; ua = '0; ub = '0;

        op_mult = m; op_div = d; value_A = a; value_B = b;
        wr_hi = whi; wr_lo = wlo; wr_data = wd;

        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) begin
                op_mult = 0; op_div = 0; wr_hi = 0; wr_lo = 0;
                value_A = $urandom; value_B = $urandom; wr_data = $urandom;
                ua = unit_A; ub = unit_B;
            end
            if (c == 3 && do_poke) begin
                op_mult = 1; op_div = 1; wr_hi = 1; wr_lo = 1; wr_data = pd;
            end
            if (c == 4) begin
                op_mult = 0; op_div = 0; wr_hi = 0; wr_lo = 0;
            end
            if (mult_start) begin ms_cnt++; if (ms_first == 0) ms_first = c; end
            if (div_start) ds_cnt++;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
            if (timeout) begin to_cnt++; if (to_cyc == 0) to_cyc = c; end
            if (div_zero) begin dz_cnt++; if (dz_cyc == 0) dz_cyc = c; end
        end
        noise_en = 1'b0;

        check("mult_start_count", 64'(ms_cnt), 64'(l_mult));
        if (l_mult) check("mult_start_cycle", 64'(ms_first), 64'(1));
        check("div_start_count", 64'(ds_cnt), 64'(l_div));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        check("done_count", 64'(done_cnt), 64'(launched && lat > 0));
        if (launched && lat > 0) check("done_cycle", 64'(done_cyc), 64'(lat + 2));
        check("timeout_count", 64'(to_cnt), 64'(launched && lat == 0));
        if (launched && lat == 0) check("timeout_cycle", 64'(to_cyc), 64'(TO + 1));
        check("div_zero_count", 64'(dz_cnt), 64'(dz));
        if (dz) check("div_zero_cycle", 64'(dz_cyc), 64'(1));
        if (launched) begin
            check("unit_A", 64'(ua), 64'(a));
            check("unit_B", 64'(ub), 64'(b));
        end
        check("hi", 64'(hi), 64'(exp_hi));
        check("lo", 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int kind, lat, post_done, post_busy;
        logic [W-1:0] a, b;

        reset = 1'b1;
        op_mult = 0; op_div = 0; value_A = '0; value_B = '0;
        wr_hi = 0; wr_lo = 0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("reset_pulses_busy", 64'({busy, done, div_zero, timeout, mult_start, div_start}), 64'(0));
        check("reset_hi_lo", {hi, lo}, 64'(0));
        check("reset_units", {unit_A, unit_B}, 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // 7 * -3 with a 32-cycle multiplier, stray div_done and busy pokes
        run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 32, 0, 0, '0, 1, 32'h1234_5678, 1);
        check("mult_7x-3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // 100 / 7
        run_op(0, 1, 32'd100, 32'd7, 31, 0, 0, '0, 1, 32'h0, 1);
        check("div_100/7", {hi, lo}, {32'd2, 32'd14});

        // divide by zero with HI preloaded to 5
        run_op(0, 0, '0, '0, 0, 1, 0, 32'd5, 0, '0, 0);
        run_op(0, 1, 32'd123, 32'd0, 5, 0, 0, '0, 0, '0, 0);
        check("div_zero_hi_kept", 64'(hi), 64'(5));

        // multiplier never answers
        run_op(1, 0, 32'd9, 32'd9, 0, 0, 0, '0, 1, 32'hFFFF, 0);

        // simultaneous requests: mult wins; write in request cycle is dropped
        run_op(1, 1, 32'd6, 32'd5, 5, 1, 1, 32'h5555, 0, '0, 0);
        check("mult_wins", 64'(lo), 64'(30));

        // MTHI while busy is dropped, then lands in IDLE
        run_op(1, 0, 32'd3, 32'd4, 8, 0, 0, '0, 1, 32'hABCD, 0);
        run_op(0, 0, '0, '0, 0, 1, 0, 32'hABCD, 0, '0, 0);
        check("mthi_idle", 64'(hi), 64'h0000_ABCD);

        // reset mid-run, then a late mult_done must be ignored
        m_lat = 20; d_lat = 0;
        op_mult = 1; value_A = 32'd11; value_B = 32'd13;
        @(negedge clk);
        op_mult = 0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mid_busy", 64'(busy), 64'(0));
        check("reset_mid_outs", 64'({done, div_zero, timeout, mult_start, div_start}), 64'(0));
        check("reset_mid_hi_lo", {hi, lo}, 64'(0));
        check("reset_mid_units", {unit_A, unit_B}, 64'(0));
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        post_done = 0; post_busy = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) post_done++;
            if (busy) post_busy++;
        end
        check("late_done_ignored", 64'(post_done), 64'(0));
        check("late_busy", 64'(post_busy), 64'(0));
        check("late_hi_lo", {hi, lo}, 64'(0));

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 6);
            lat  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            a    = $urandom;
            b    = $urandom;
            if (b == 0) b = 1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            case (kind)
                0, 1: run_op(1, 0, a, b, lat, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 1, $urandom, $urandom_range(0, 1));
                2, 3: run_op(0, 1, a, b, lat, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 1, $urandom, $urandom_range(0, 1));
                4:    run_op(0, 1, a, '0, lat, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 0, '0, 0);
                5:    run_op(1, 1, a, b, lat, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 1, $urandom, 0);
                default: run_op(0, 0, a, b, lat, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, 0, '0, 0);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Controller between the CPU control unit and the multicycle mult (Booth) and div units.
- Accepts one MULT or DIV request at a time, latches operands, launches the selected unit with a start pulse, and waits for its done.
- Owns the architectural HI/LO registers and writes them on completion.
- Holds a stall (busy) line high for the control unit, and flags divide-by-zero and unit timeout.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- TIMEOUT, 40, maximum cycles in a RUN state before abort; must be >= 2 and < 2^CNT_W.
- CNT_W, 6, width of the cycle counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op_mult  in  1  request signed multiply (sampled only in IDLE)
- op_div  in  1  request signed divide (sampled only in IDLE)
- value_A  in  WIDTH  operand A (multiplicand / dividend)
- value_B  in  WIDTH  operand B (multiplier / divisor)
- wr_hi  in  1  MTHI write strobe
- wr_lo  in  1  MTLO write strobe
- wr_data  in  WIDTH  MTHI/MTLO data
- mult_start  out  1  one-cycle launch pulse to multiplier
- mult_done  in  1  multiplier result valid
- mult_hi, mult_lo  in  WIDTH each  multiplier result
- div_start  out  1  one-cycle launch pulse to divider
- div_done  in  1  divider result valid
- div_hi, div_lo  in  WIDTH each  remainder / quotient
- unit_A, unit_B  out  WIDTH each  latched operands driven to both units
- busy  out  1  stall to control unit
- done  out  1  one-cycle pulse: HI/LO updated by a mult/div
- div_zero  out  1  one-cycle pulse: divide by zero, no launch
- timeout  out  1  one-cycle pulse: unit did not finish in time
- hi, lo  out  WIDTH each  architectural HI/LO registers

Behaviour:
- Reset: asynchronous, active-high.
  - State IDLE; hi, lo, unit_A, unit_B, counter = 0.
  - mult_start, div_start, busy, done, div_zero, timeout = 0.
  - Reset asserted mid-operation aborts the operation; no HI/LO write; start lines drop immediately.
- States: IDLE, MULT_RUN, DIV_RUN.
- IDLE, at each edge, in priority order:
  - op_mult=1: latch A/B into unit_A/unit_B; go to MULT_RUN; mult_start=1 for the next cycle only; busy=1; counter=0.
  - else op_div=1 with value_B!=0: same as above, but DIV_RUN and div_start.
  - else op_div=1 with value_B==0: div_zero=1 for one cycle; stay IDLE; busy stays 0; HI/LO unchanged.
  - Simultaneous op_mult and op_div: mult wins and div is dropped.
- MULT_RUN / DIV_RUN:
  - The counter increments every cycle.
  - On an edge sampling the selected unit's done=1: load hi/lo from that unit's result; done=1 next cycle; busy=0 next cycle; return to IDLE.
  - The other unit's done is ignored.
  - If done is not seen and counter==TIMEOUT-1: timeout=1 for one cycle; busy=0; return to IDLE; HI/LO unchanged.
  - op_mult and op_div are ignored while not in IDLE (no queueing).
- Latency: request edge -> start pulse cycle 1 -> busy high from cycle 1 through the cycle the unit's done is sampled.
  - done pulse and busy fall occur together, one cycle after done is sampled.
  - Minimum total is 2 cycles with a unit that answers immediately after start.
- MTHI/MTLO:
  - wr_hi/wr_lo load hi/lo from wr_data at the edge, only in IDLE with no op_* accepted that same cycle.
  - An accepted op_* takes precedence and the write is dropped.
  - Writes while busy are dropped.
  - wr_hi and wr_lo together write both registers with the same data.
- All outputs are registered; done, div_zero, timeout and *_start are never high for more than one consecutive cycle.

Test Plan:
- Bench mult model returns hi=0xFFFFFFFF, lo=0xFFFFFFEB after 33 cycles. Stimulus: reset, then op_mult with A=7, B=-3 (0xFFFFFFFD). Required: mult_start pulse at cycle 1; busy high cycles 1..33; done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- op_div with A=100, B=7, div model answers hi=2, lo=14 after 32 cycles. Required: div_start only (no mult_start); hi=2, lo=14; done pulse.
- op_div with B=0 and hi=5 preloaded. Required: div_zero pulse next cycle; busy never rises; no div_start; hi stays 5.
- mult model never asserts done, TIMEOUT=40. Required: timeout pulse exactly 40 cycles after mult_start; busy falls; HI/LO unchanged.
- Contention and precedence:
  - op_mult and op_div in the same cycle: only mult runs.
  - Second op_mult while busy: ignored, no extra start.
  - wr_hi=1 with data 0xABCD while busy: dropped. The same write in IDLE: hi=0xABCD.
- Reset asserted at cycle 10 of a mult run. Required: immediately busy=0, all outputs 0, state IDLE. A late mult_done afterwards is ignored.
